// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, constants and strobe-merge helper for the instruction-memory responder
package imem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned STRB_W = WORD_W / 8;
    localparam logic [WORD_W-1:0] NOP_INSN_DEFAULT = 32'h00000013;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
        logic              fault;
    } rsp_stage_t;

    function automatic logic [WORD_W-1:0] merge_strb(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [WORD_W-1:0] res;
        res = old_word;
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/imem_resp_stage.sv
// rtl/imem_resp_stage.sv - one response pipeline register with hold enable and async clear
module imem_resp_stage
    import imem_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_hold,
    input  rsp_stage_t i_d,
    output rsp_stage_t o_q
);

    rsp_stage_t stage_q, stage_d;

    always_comb begin
        stage_d = stage_q;
        if (!i_hold) stage_d = i_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) stage_q <= '0;
        else          stage_q <= stage_d;
    end

    assign o_q = stage_q;

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder with fixed-latency valid/ready fetch pipeline
module imem_responder
    import imem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h00000000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] NOP_INSN  = NOP_INSN_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic [31:0] o_rsp_addr,
    output logic        o_rsp_fault,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_addr,
    input  logic [31:0] i_wr_data,
    input  logic [3:0]  i_wr_strb
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    // One bit wider than an address so the limit never wraps to zero.
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

    logic [WORD_W-1:0] mem_q [DEPTH];

    logic [31:0]      rd_off, wr_off;
    logic             rd_fault, wr_fault;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic             advance;
    rsp_stage_t       s1_d, s1_q;
    rsp_stage_t       pipe [LATENCY];

    always_comb begin
        rd_off   = i_req_addr - BASE_ADDR;
        rd_fault = (rd_off[1:0] != 2'b00) || ({1'b0, rd_off} >= LIMIT);
        rd_idx   = rd_off[IDX_W+1:2];
        wr_off   = i_wr_addr - BASE_ADDR;
        wr_fault = (wr_off[1:0] != 2'b00) || ({1'b0, wr_off} >= LIMIT);
        wr_idx   = wr_off[IDX_W+1:2];
    end

    assign advance     = !(pipe[LATENCY-1].valid && !i_rsp_ready);
    assign o_req_ready = advance;

    // The array is read combinationally here, so a same-edge write lands after this capture.
    always_comb begin
        s1_d = s1_q;
        if (advance) begin
            s1_d.valid = i_req_valid;
            s1_d.addr  = i_req_addr;
            s1_d.fault = rd_fault;
            s1_d.data  = rd_fault ? NOP_INSN : mem_q[rd_idx];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) s1_q <= '0;
        else          s1_q <= s1_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en && !wr_fault) begin
            mem_q[wr_idx] <= merge_strb(mem_q[wr_idx], i_wr_data, i_wr_strb);
        end
    end

    assign pipe[0] = s1_q;

    for (genvar g = 1; g < int'(LATENCY); g++) begin : g_stage
        imem_resp_stage u_stage (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_hold  (!advance),
            .i_d     (pipe[g-1]),
            .o_q     (pipe[g])
        );
    end

    assign o_rsp_valid = pipe[LATENCY-1].valid;
    assign o_rsp_rdata = pipe[LATENCY-1].data;
    assign o_rsp_addr  = pipe[LATENCY-1].addr;
    assign o_rsp_fault = pipe[LATENCY-1].fault;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed self-checking bench for imem_responder at latencies 1, 3 and 4
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid1, req_valid3, req_valid4;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;

    logic        req_ready1, req_ready3, req_ready4;
    logic        rsp_valid1, rsp_valid3, rsp_valid4;
    logic [31:0] rsp_rdata1, rsp_rdata3, rsp_rdata4;
    logic [31:0] rsp_addr1, rsp_addr3, rsp_addr4;
    logic        rsp_fault1, rsp_fault3, rsp_fault4;

    int checks = 0;
    int errors = 0;
    int stale;

    always #5 clk = ~clk;

    imem_responder #(.LATENCY(1)) u_lat1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid1), .o_req_ready(req_ready1), .i_req_addr(req_addr),
        .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata1),
        .o_rsp_addr(rsp_addr1), .o_rsp_fault(rsp_fault1),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_strb(wr_strb)
    );

    imem_responder #(.LATENCY(3)) u_lat3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid3), .o_req_ready(req_ready3), .i_req_addr(req_addr),
        .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata3),
        .o_rsp_addr(rsp_addr3), .o_rsp_fault(rsp_fault3),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_strb(wr_strb)
    );

    imem_responder #(.LATENCY(4)) u_lat4 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid4), .o_req_ready(req_ready4), .i_req_addr(req_addr),
        .o_rsp_valid(rsp_valid4), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata4),
        .o_rsp_addr(rsp_addr4), .o_rsp_fault(rsp_fault4),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_strb(wr_strb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req_valid1 = 1'b1; req_valid3 = 1'b1; req_valid4 = 1'b1;
        req_addr = 32'h0; rsp_ready = 1'b1;
        wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0; wr_strb = 4'h0;

        repeat (3) step();
        check("rst_valid1", 32'(rsp_valid1), 32'd0);
        check("rst_rdata1", rsp_rdata1, 32'h0);
        check("rst_addr1",  rsp_addr1,  32'h0);
        check("rst_fault1", 32'(rsp_fault1), 32'd0);
        check("rst_valid4", 32'(rsp_valid4), 32'd0);

        rst_n = 1'b1;
        req_valid1 = 1'b0; req_valid3 = 1'b0; req_valid4 = 1'b0;

        wr(32'h0,   32'h00500093, 4'hF);
        wr(32'h4,   32'h00100113, 4'hF);
        wr(32'h8,   32'hDEADBEEF, 4'hF);
        wr(32'h10,  32'h11223344, 4'hF);
        wr(32'hFFC, 32'hCAFEF00D, 4'hF);
        wr(32'h1000, 32'hFFFFFFFF, 4'hF);
        wr(32'h2,    32'hFFFFFFFF, 4'hF);

        // Back-to-back fetches at latency 1
        check("b_ready", 32'(req_ready1), 32'd1);
        req_valid1 = 1'b1; req_addr = 32'h0;
        step();
        check("b0_valid", 32'(rsp_valid1), 32'd1);
        check("b0_data",  rsp_rdata1, 32'h00500093);
        check("b0_addr",  rsp_addr1, 32'h0);
        check("b0_fault", 32'(rsp_fault1), 32'd0);
        req_addr = 32'h4;
        step();
        check("b1_valid", 32'(rsp_valid1), 32'd1);
        check("b1_data",  rsp_rdata1, 32'h00100113);
        check("b1_addr",  rsp_addr1, 32'h4);
        req_valid1 = 1'b0;
        step();
        check("b_idle", 32'(rsp_valid1), 32'd0);

        // Latency 3: visible after accepting edge + 2
        req_valid3 = 1'b1; req_addr = 32'h8;
        step();
        req_valid3 = 1'b0;
        check("lat_e0", 32'(rsp_valid3), 32'd0);
        step();
        check("lat_e1", 32'(rsp_valid3), 32'd0);
        step();
        check("lat_e2_valid", 32'(rsp_valid3), 32'd1);
        check("lat_e2_data",  rsp_rdata3, 32'hDEADBEEF);
        check("lat_e2_addr",  rsp_addr3, 32'h8);
        step();
        check("lat_e3_gone", 32'(rsp_valid3), 32'd0);

        // Backpressure at latency 1
        req_valid1 = 1'b1; req_addr = 32'h0;
        step();
        rsp_ready = 1'b0; req_addr = 32'h4;
        #1;
        check("bp_ready_drop", 32'(req_ready1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_hold_valid", 32'(rsp_valid1), 32'd1);
            check("bp_hold_data",  rsp_rdata1, 32'h00500093);
            check("bp_hold_addr",  rsp_addr1, 32'h0);
            check("bp_hold_ready", 32'(req_ready1), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        check("bp_r1_data", rsp_rdata1, 32'h00100113);
        check("bp_r1_addr", rsp_addr1, 32'h4);
        req_addr = 32'h8;
        step();
        check("bp_r2_data", rsp_rdata1, 32'hDEADBEEF);
        check("bp_r2_addr", rsp_addr1, 32'h8);
        req_valid1 = 1'b0;
        step();
        check("bp_idle", 32'(rsp_valid1), 32'd0);

        // Faults and range boundaries
        req_valid1 = 1'b1; req_addr = 32'h2;
        step();
        check("f_mis_fault", 32'(rsp_fault1), 32'd1);
        check("f_mis_data",  rsp_rdata1, 32'h00000013);
        check("f_mis_addr",  rsp_addr1, 32'h2);
        req_addr = 32'h1000;
        step();
        check("f_oor_fault", 32'(rsp_fault1), 32'd1);
        check("f_oor_data",  rsp_rdata1, 32'h00000013);
        req_addr = 32'hFFFFFFFC;
        step();
        check("f_wrap_fault", 32'(rsp_fault1), 32'd1);
        check("f_wrap_data",  rsp_rdata1, 32'h00000013);
        check("f_wrap_addr",  rsp_addr1, 32'hFFFFFFFC);
        req_addr = 32'hFFC;
        step();
        check("f_last_fault", 32'(rsp_fault1), 32'd0);
        check("f_last_data",  rsp_rdata1, 32'hCAFEF00D);
        req_addr = 32'h0;
        step();
        check("f_wdrop_data", rsp_rdata1, 32'h00500093);
        req_valid1 = 1'b0;
        step();

        // Strobed write colliding with a read of the same word
        req_valid1 = 1'b1; req_addr = 32'h10;
        wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'hAABBCCDD; wr_strb = 4'b0101;
        step();
        wr_en = 1'b0;
        check("col_old", rsp_rdata1, 32'h11223344);
        step();
        check("col_new", rsp_rdata1, 32'h11BB33DD);
        req_valid1 = 1'b0;
        step();

        // Reset mid-flight at latency 4
        req_valid4 = 1'b1;
        req_addr = 32'h0;  step();
        req_addr = 32'h4;  step();
        req_addr = 32'h8;  step();
        req_addr = 32'h10; step();
        req_valid4 = 1'b0;
        check("rmf_pre_valid", 32'(rsp_valid4), 32'd1);
        check("rmf_pre_data",  rsp_rdata4, 32'h00500093);
        #3;
        rst_n = 1'b0;
        #1;
        check("rmf_drop_valid", 32'(rsp_valid4), 32'd0);
        check("rmf_drop_data",  rsp_rdata4, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            step();
            if (rsp_valid4) stale++;
        end
        check("rmf_stale", 32'(stale), 32'd0);
        check("rmf_ready", 32'(req_ready4), 32'd1);
        req_valid4 = 1'b1; req_addr = 32'h10;
        step();
        req_valid4 = 1'b0;
        repeat (3) step();
        check("rmf_keep_valid", 32'(rsp_valid4), 32'd1);
        check("rmf_keep_data",  rsp_rdata4, 32'h11BB33DD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
